stage_instruction_fetch_buffered: RTL
=====================================

Name: stage_instruction_fetch_buffered

Overview:
Parametrised fetch stage with a variable-latency instruction-memory handshake and a DEPTH-entry instruction queue feeding the decode pipeline register. It decouples memory latency from decode stalls, keeps up to MAX_OUTSTANDING requests in flight and discards stale responses after an execute-stage redirect. It sits between the instruction memory and stage decode, driving the de_* pipeline register.

Parameters:
PC_W, 32, program counter / address width
INSTR_W, 32, instruction width
DEPTH, 4, instruction queue entries (power of two, >=2)
MAX_OUTSTANDING, 2, max accepted-but-unanswered requests (1..DEPTH)
RESET_VECTOR, 0, PC after reset (word aligned)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
if_stall  in  1  hazard unit: suppress new fetch requests
de_stall  in  1  hold de_* register
de_clear  in  1  clear de_* register (bubble)
ex_pc_src  in  1  redirect request from execute
ex_pc_target  in  PC_W  redirect target
imem_req  out  1  request valid
imem_addr  out  PC_W  request address
imem_ready  in  1  memory accepts request (handshake on imem_req & imem_ready)
imem_rvalid  in  1  response valid, responses strictly in request order
imem_rdata  in  INSTR_W  response instruction
de_valid  out  1  de_* holds a real instruction
de_instr  out  INSTR_W  instruction to decode
de_pc  out  PC_W  address of de_instr
de_pc_plus4  out  PC_W  de_pc + 4

Behaviour:
- Reset (rst=1 at posedge): fetch_pc=RESET_VECTOR, resp_pc=RESET_VECTOR, queue empty, outstanding=0, drop_cnt=0, de_valid=0, de_instr/de_pc/de_pc_plus4=0. imem_req=0 while rst=1. Reset mid-burst abandons in-flight requests; responses arriving after reset release are accepted as new data, so memory must be reset together with this block.
- Issue: imem_req = !rst & !if_stall & !ex_pc_src & (outstanding < MAX_OUTSTANDING) & (q_count + outstanding - drop_cnt < DEPTH). imem_addr = fetch_pc. On accept, fetch_pc += 4 and outstanding += 1.
- Response: on imem_rvalid, outstanding -= 1. If drop_cnt>0, the response is discarded and drop_cnt -= 1. Otherwise push {imem_rdata, resp_pc} into the queue and resp_pc += 4. The credit rule guarantees no push when full; a response into a full queue is an assertion failure.
- Decode load (priority order): de_clear sets de_valid=0 and zeros the de_* data with no pop. Otherwise de_stall holds everything. Otherwise, if the queue is non-empty and ex_pc_src=0, pop the head into de_*, set de_valid=1 and de_pc_plus4=head pc+4. Otherwise de_valid=0.
- Latency: a response accepted at edge N appears in de_* at edge N+1 when there is no stall. Reset-to-first imem_req is 1 cycle.
- Redirect (ex_pc_src=1): fetch_pc and resp_pc load {ex_pc_target[PC_W-1:2],2'b00}. The queue is flushed with no pop that cycle. drop_cnt = drop_cnt + (outstanding - drop_cnt) + accept - rvalid, so every in-flight request is dropped, including one accepted the same cycle (none, since imem_req=0). A response arriving in the redirect cycle is discarded. de_* is not affected except through de_clear, which the hazard unit asserts alongside.
- Simultaneous push and pop are allowed at any occupancy, including full with a pop.
- Pointer arithmetic wraps mod DEPTH. q_count range is 0..DEPTH. Counters are sized clog2 of their maximum plus 1.

Optional Feature:
FETCH_PERF_EN. When defined, adds three 32-bit outputs:
- perf_fetched: counts decode loads with de_valid=1.
- perf_redirects: counts ex_pc_src cycles.
- perf_starve: counts cycles with !de_stall, queue empty and no de_clear.
All three reset to 0 and wrap. When undefined, these ports and their counters do not exist and the remaining behaviour is identical.

Test Plan:
- Reset with a 1-cycle-latency memory that is always ready, no stalls -> imem_addr sequence 0,4,8,..., first de_valid at cycle 3, de_pc increments by 4 each cycle, de_pc_plus4=de_pc+4.
- Hold de_stall=1 for 10 cycles -> queue fills to DEPTH=4, imem_req drops, de_* frozen. After release, 4 sequential instructions arrive with no gap or duplicate.
- Memory latency 3, 2 requests outstanding, ex_pc_src=1 with target 0x100 -> both stale responses dropped, next de_pc=0x100, no instruction from 0x0-0x0C reaches de_valid.
- Redirect to 0x102 -> imem_addr=0x100.
- de_clear and de_stall asserted together with a non-empty queue -> de_valid=0, queue count unchanged.
- Assert rst while 2 requests are outstanding -> all outputs return to reset values and fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/stage_instruction_fetch_buffered.sv
// Buffered fetch stage: variable-latency imem handshake, DEPTH-entry instruction queue, de_* pipeline register.
// Optional FETCH_PERF_EN adds perf_fetched / perf_redirects / perf_starve counters.
module stage_instruction_fetch_buffered #(
    parameter int unsigned     PC_W            = 32,
    parameter int unsigned     INSTR_W         = 32,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [PC_W-1:0] RESET_VECTOR    = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_stall,
    input  logic               de_stall,
    input  logic               de_clear,
    input  logic               ex_pc_src,
    input  logic [PC_W-1:0]    ex_pc_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               de_valid,
    output logic [INSTR_W-1:0] de_instr,
    output logic [PC_W-1:0]    de_pc,
    output logic [PC_W-1:0]    de_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_redirects,
    output logic [31:0]        perf_starve
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    resp_pc;
    logic [PC_W-1:0]    redirect_pc;
    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [PC_W-1:0]    q_pc    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   q_count;
    logic [OUT_W-1:0]   outstanding;
    logic [OUT_W-1:0]   drop_cnt;
    logic [OUT_W-1:0]   outstanding_next;
    logic [31:0]        credit_used;
    logic               accept;
    logic               push;
    logic               pop;
    logic               q_empty;

    assign redirect_pc = {ex_pc_target[PC_W-1:2], 2'b00};
    assign q_empty     = (q_count == '0);

    // Credits cover queued entries plus live (not-yet-dropped) requests, so a response always finds room.
    assign credit_used = 32'(q_count) + 32'(outstanding) - 32'(drop_cnt);
    assign imem_req    = !rst && !if_stall && !ex_pc_src
                         && (32'(outstanding) < 32'(MAX_OUTSTANDING))
                         && (credit_used < 32'(DEPTH));
    assign imem_addr   = fetch_pc;
    assign accept      = imem_req && imem_ready;

    assign outstanding_next = outstanding + OUT_W'(accept) - OUT_W'(imem_rvalid);

    // A response in the redirect cycle belongs to the old path and is discarded.
    assign push = imem_rvalid && (drop_cnt == '0) && !ex_pc_src;
    assign pop  = !de_clear && !de_stall && !q_empty && !ex_pc_src;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_VECTOR;
            resp_pc     <= RESET_VECTOR;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (ex_pc_src) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                drop_cnt <= outstanding_next;
            end else begin
                if (accept) fetch_pc <= fetch_pc + PC_W'(4);
                if (push)   resp_pc  <= resp_pc + PC_W'(4);
                if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - OUT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || ex_pc_src) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            q_count <= q_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: queue storage has no reset; validity is tracked by q_count, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= resp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || de_clear) begin
            de_valid    <= 1'b0;
            de_instr    <= '0;
            de_pc       <= '0;
            de_pc_plus4 <= '0;
        end else if (!de_stall) begin
            de_valid <= pop;
            if (pop) begin
                de_instr    <= q_instr[rd_ptr];
                de_pc       <= q_pc[rd_ptr];
                de_pc_plus4 <= q_pc[rd_ptr] + PC_W'(4);
            end
        end
    end

    push_into_full: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (q_count == CNT_W'(DEPTH))));

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
            perf_starve    <= '0;
        end else begin
            if (pop)       perf_fetched   <= perf_fetched + 32'd1;
            if (ex_pc_src) perf_redirects <= perf_redirects + 32'd1;
            if (!de_stall && q_empty && !de_clear) perf_starve <= perf_starve + 32'd1;
        end
    end
`endif

endmodule
